pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Stall/flush scheduler for the 5-stage non-forwarding RV32I pipeline.
- Keeps a per-register pending-write scoreboard and stalls ID until every source operand has been written back.
- Squashes wrong-path instructions on a taken branch and freezes the whole pipe while the LSU is busy.
- Drives the PC/stage-register enables and flushes, plus the retire-valid strobe (insn_vld) seen by the scoreboard testbench.

Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- WB_DIST, 3, pipeline stages from ID/EX edge to register-file write. Scoreboard load value = WB_DIST-1, because the register file is write-through.
- CNT_W, 2, scoreboard counter width; must satisfy 2^CNT_W > WB_DIST-1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- id_vld_i  in  1  IF/ID register holds a real instruction
- id_rs1_i  in  5  ID source 1 index
- id_rs2_i  in  5  ID source 2 index
- id_rs1_use_i  in  1  instruction reads rs1
- id_rs2_use_i  in  1  instruction reads rs2
- id_rd_i  in  5  ID destination index
- id_rd_wen_i  in  1  instruction writes rd
- ex_br_taken_i  in  1  branch/jump in EX redirects the PC this cycle
- mem_busy_i  in  1  LSU not ready; freeze the pipe
- pc_en_o  out  1  PC register load enable
- if_id_en_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  clear IF/ID to NOP
- id_ex_flush_o  out  1  load bubble into ID/EX
- pipe_en_o  out  1  EX/MEM and MEM/WB enable
- insn_vld_o  out  1  instruction retiring in WB this cycle
- stall_cnt_o  out  32  hazard-stall cycles (optional feature)
- flush_cnt_o  out  32  taken-branch flushes (optional feature)

Behaviour:
- State:
  - sb_cnt[1..31], CNT_W bits each.
  - Valid pipe v_ex, v_mem, v_wb.
  - insn_vld_o = v_wb (registered).
- Hazard: haz = id_vld_i & ((id_rs1_use_i & rs1!=0 & sb_cnt[rs1]!=0) | (id_rs2_use_i & rs2!=0 & sb_cnt[rs2]!=0)).
- Control priority, highest first, all outputs combinational from state and inputs:
  - FREEZE (mem_busy_i): pc_en=0, if_id_en=0, pipe_en=0, no flushes. State (counters, valid pipe) holds.
  - REDIRECT (ex_br_taken_i): pc_en=1, if_id_flush=1, id_ex_flush=1, pipe_en=1. The ID instruction is killed and does not issue.
  - STALL (haz): pc_en=0, if_id_en=0, id_ex_flush=1, pipe_en=1.
  - RUN: all enables 1, no flushes.
- issue = id_vld_i & ~mem_busy_i & ~ex_br_taken_i & ~haz.
- Each non-frozen cycle: v_wb<=v_mem, v_mem<=v_ex, v_ex<=issue. Every nonzero sb_cnt decrements by 1.
- On issue with id_rd_wen_i & rd!=0: sb_cnt[rd]<=WB_DIST-1. The load wins over the same-cycle decrement of that entry; a WAW re-issue reloads.
- Latency: the dependent instruction immediately after its producer stalls exactly WB_DIST-1 = 2 cycles; one independent instruction between them reduces this to 1 stall.
- A branch flush does not alter sb_cnt, because the producers are older than the branch.
- A redirect that arrives during FREEZE is deferred until mem_busy_i drops. ex_br_taken_i must be held by EX while frozen.
- Reset (any cycle, including mid-stall or mid-freeze) clears all sb_cnt, v_* and counters. While rst_i=1: pc_en_o=0, if_id_en_o=0, if_id_flush_o=1, id_ex_flush_o=1, pipe_en_o=0, insn_vld_o=0.
- First cycle after reset is RUN with an empty scoreboard.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - stall_cnt_o increments on every STALL cycle.
  - flush_cnt_o increments on every REDIRECT cycle.
  - Both exclude FREEZE and reset, wrap at 2^32, and reset to 0.
- PIPE_PERF_CNT_EN undefined: both outputs tied to 0 and no counter flops exist.

Test Plan:
- Producer `addi x5,x0,1` followed by consumer `add x6,x5,x5` -> exactly 2 STALL cycles (pc_en_o=0, id_ex_flush_o=1). The consumer issues in cycle 3, and insn_vld_o pulses once per instruction; with PIPE_PERF_CNT_EN, stall_cnt_o=2.
- Producer writes x0, consumer reads x0 -> no stall, sb_cnt untouched.
- A taken branch in EX arrives in the same cycle as an ID hazard -> REDIRECT wins: if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1, the killed instruction never raises insn_vld_o, and flush_cnt_o=1.
- mem_busy_i held 4 cycles during a pending hazard (sb_cnt[x5]=2) -> all enables 0, sb_cnt[x5] remains 2, and the stall resumes for 2 more cycles after release.
- Back-to-back writes to x7, then a read of x7 -> the stall counts from the second write, 2 cycles after it issues.
- rst_i asserted for 1 cycle mid-stall -> the next cycle is RUN with no stall, the valid pipe is empty, and insn_vld_o=0 for 3 cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage non-forwarding RV32I pipeline.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int WB_DIST  = 3,
    parameter int CNT_W    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_vld_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_rd_wen_i,
    input  logic        ex_br_taken_i,
    input  logic        mem_busy_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        pipe_en_o,
    output logic        insn_vld_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    // Write-through register file: the consumer may read in the cycle of the write.
    localparam logic [CNT_W-1:0] SB_LOAD = CNT_W'(WB_DIST - 1);

    typedef enum logic [2:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_REDIRECT,
        MODE_FREEZE,
        MODE_RESET
    } mode_e;

    mode_e            mode;
    logic [CNT_W-1:0] sb_cnt_q [NUM_REGS];
    logic [CNT_W-1:0] sb_cnt_d [NUM_REGS];
    logic             v_ex_q, v_mem_q, v_wb_q;
    logic             rs1_pend, rs2_pend, haz, issue;

    assign rs1_pend = id_rs1_use_i && (id_rs1_i != 5'd0) && (sb_cnt_q[id_rs1_i] != '0);
    assign rs2_pend = id_rs2_use_i && (id_rs2_i != 5'd0) && (sb_cnt_q[id_rs2_i] != '0);
    assign haz      = id_vld_i && (rs1_pend || rs2_pend);

    always_comb begin
        mode = MODE_RUN;
        if (rst_i) begin
            mode = MODE_RESET;
        end else if (mem_busy_i) begin
            mode = MODE_FREEZE;
        end else if (ex_br_taken_i) begin
            mode = MODE_REDIRECT;
        end else if (haz) begin
            mode = MODE_STALL;
        end
    end

    assign issue = id_vld_i && (mode == MODE_RUN);

    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pipe_en_o     = 1'b1;
        case (mode)
            MODE_RESET: begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                pipe_en_o     = 1'b0;
            end
            MODE_FREEZE: begin
                pc_en_o    = 1'b0;
                if_id_en_o = 1'b0;
                pipe_en_o  = 1'b0;
            end
            MODE_REDIRECT: begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
            MODE_STALL: begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The issue load is applied after the decrement so that it wins on a same-cycle hit.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_cnt_d[i] = sb_cnt_q[i];
        end
        if (!mem_busy_i) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (sb_cnt_q[i] != '0) begin
                    sb_cnt_d[i] = sb_cnt_q[i] - 1'b1;
                end
            end
            if (issue && id_rd_wen_i && (id_rd_i != 5'd0)) begin
                sb_cnt_d[id_rd_i] = SB_LOAD;
            end
        end
        sb_cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_cnt_q[i] <= '0;
            end
            v_ex_q  <= 1'b0;
            v_mem_q <= 1'b0;
            v_wb_q  <= 1'b0;
        end else begin
            sb_cnt_q <= sb_cnt_d;
            if (!mem_busy_i) begin
                v_ex_q  <= issue;
                v_mem_q <= v_ex_q;
                v_wb_q  <= v_mem_q;
            end
        end
    end

    assign insn_vld_o = v_wb_q && !rst_i;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mode == MODE_STALL) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (mode == MODE_REDIRECT) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a register-ready-time model.
// Expected count outputs follow PIPE_PERF_CNT_EN in the same way as the design.
module tb_pipe_hazard_ctrl;

    localparam int WB = 3;
    localparam int W  = 70;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_vld_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_rs1_use_i, id_rs2_use_i, id_rd_wen_i;
    logic        ex_br_taken_i, mem_busy_i;
    logic        pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, pipe_en_o, insn_vld_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    pipe_hazard_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_vld_i      (id_vld_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_use_i  (id_rs1_use_i),
        .id_rs2_use_i  (id_rs2_use_i),
        .id_rd_i       (id_rd_i),
        .id_rd_wen_i   (id_rd_wen_i),
        .ex_br_taken_i (ex_br_taken_i),
        .mem_busy_i    (mem_busy_i),
        .pc_en_o       (pc_en_o),
        .if_id_en_o    (if_id_en_o),
        .if_id_flush_o (if_id_flush_o),
        .id_ex_flush_o (id_ex_flush_o),
        .pipe_en_o     (pipe_en_o),
        .insn_vld_o    (insn_vld_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: a register becomes readable WB pipe advances after its writer issues.
    int          step;
    int          ready_step [32];
    bit          issued [int];
    logic [31:0] m_stall, m_flush;

    logic [W-1:0] exp_q [$];
    int           errors = 0;
    int           checks = 0;
    bit           mon_en = 1'b0;

    task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd, input logic wen,
                         input logic br, input logic busy, input logic rst);
        logic h, e_pc, e_ifen, e_iff, e_idf, e_pipe, e_vld;
        logic [31:0] e_stall, e_flush;
        id_vld_i = vld; id_rs1_i = rs1; id_rs2_i = rs2;
        id_rs1_use_i = u1; id_rs2_use_i = u2; id_rd_i = rd; id_rd_wen_i = wen;
        ex_br_taken_i = br; mem_busy_i = busy; rst_i = rst;

        h = vld && ((u1 && rs1 != 5'd0 && step < ready_step[rs1]) ||
                    (u2 && rs2 != 5'd0 && step < ready_step[rs2]));
        e_vld = !rst && issued.exists(step - WB);
        if (rst) begin
            {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b00110;
        end else if (busy) begin
            {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b00000;
        end else if (br) begin
            {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b11111;
        end else if (h) begin
            {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b00011;
        end else begin
            {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b11001;
        end
`ifdef PIPE_PERF_CNT_EN
        e_stall = m_stall;
        e_flush = m_flush;
`else
        e_stall = 32'd0;
        e_flush = 32'd0;
`endif
        exp_q.push_back({e_pc, e_ifen, e_iff, e_idf, e_pipe, e_vld, e_stall, e_flush});

        if (rst) begin
            issued.delete();
            for (int i = 0; i < 32; i++) ready_step[i] = 0;
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else if (!busy) begin
            if (br) begin
                m_flush = m_flush + 32'd1;
            end else if (h) begin
                m_stall = m_stall + 32'd1;
            end else if (vld) begin
                issued[step] = 1'b1;
                if (wen && rd != 5'd0) ready_step[rd] = step + WB;
            end
            step++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] rd);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd2(input logic [4:0] rs, input logic br, input logic busy, input logic rst);
        drive(1'b1, rs, rs, 1'b1, 1'b1, 5'd6, 1'b1, br, busy, rst);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act, e;
        if (mon_en) begin
            act = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, pipe_en_o, insn_vld_o,
                   stall_cnt_o, flush_cnt_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expect t=%0t actual=%h", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL ctrl t=%0t ctrl act=%b exp=%b stall act=%0d exp=%0d flush act=%0d exp=%0d",
                             $time, act[69:64], e[69:64], act[63:32], e[63:32], act[31:0], e[31:0]);
                end
            end
        end
    end

    initial begin
        step = 0;
        m_stall = 32'd0;
        m_flush = 32'd0;
        for (int i = 0; i < 32; i++) ready_step[i] = 0;
        rst_i = 1'b1; id_vld_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0;
        id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0; id_rd_wen_i = 1'b0;
        ex_br_taken_i = 1'b0; mem_busy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // producer x5, dependent consumer: stall, stall, issue
        wr(5'd5);
        repeat (3) rd2(5'd5, 1'b0, 1'b0, 1'b0);
        nop(4);
        // x0 never pends
        wr(5'd0);
        rd2(5'd0, 1'b0, 1'b0, 1'b0);
        nop(4);
        // redirect beats a hazard in the same cycle
        wr(5'd5);
        rd2(5'd5, 1'b1, 1'b0, 1'b0);
        nop(4);
        // freeze during a pending hazard, then the stall resumes
        wr(5'd5);
        repeat (4) rd2(5'd5, 1'b0, 1'b1, 1'b0);
        repeat (3) rd2(5'd5, 1'b0, 1'b0, 1'b0);
        nop(4);
        // back-to-back writes to x7, then a read
        wr(5'd7);
        wr(5'd7);
        repeat (3) rd2(5'd7, 1'b0, 1'b0, 1'b0);
        nop(4);
        // reset mid-stall
        wr(5'd5);
        rd2(5'd5, 1'b0, 1'b0, 1'b0);
        rd2(5'd5, 1'b0, 1'b0, 1'b1);
        rd2(5'd5, 1'b0, 1'b0, 1'b0);
        nop(4);
        // freeze while a redirect is held
        wr(5'd3);
        repeat (3) rd2(5'd3, 1'b1, 1'b1, 1'b0);
        rd2(5'd3, 1'b1, 1'b0, 1'b0);
        nop(4);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 49) == 0);
        end

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
